rx_bit_timer: RTL and testbench

RX_BIT_TIMER -- requirements
Module: rx_bit_timer

---
 rtl/rx_bit_timer_if.sv | 19 +
 rtl/rx_bit_timer.sv | 65 ++++++
 tb/tb_rx_bit_timer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rx_bit_timer_if.sv
// rtl/rx_bit_timer_if.sv - receive bit timer signal bundle
interface rx_bit_timer_if;
  logic rcving;
  logic d_edge;
  logic d_orig;
  logic shift_enable;
  logic byte_received;
  logic stuff_error;

  modport master (
    output rcving, d_edge, d_orig,
    input  shift_enable, byte_received, stuff_error
  );

  modport slave (
    input  rcving, d_edge, d_orig,
    output shift_enable, byte_received, stuff_error
  );
endinterface

// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - USB full-speed RX bit timer with bit-stuff removal
module rx_bit_timer (
  input  logic            clk,
  input  logic            n_rst,
  rx_bit_timer_if.slave   bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state;
  logic [2:0] phase;
  logic [2:0] bit_cnt;
  logic [2:0] ones;
  logic       shift_r;
  logic       byte_pend;
  logic       byte_r;
  logic       stuff_r;
  logic       sample;

  // A coincident edge resyncs the phase and suppresses the sample.
  assign sample = (state == ACTIVE) && (phase == 3'd3) && !bus.d_edge;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      phase     <= 3'd0;
      bit_cnt   <= 3'd0;
      ones      <= 3'd0;
      shift_r   <= 1'b0;
      byte_pend <= 1'b0;
      byte_r    <= 1'b0;
      stuff_r   <= 1'b0;
    end else if (!bus.rcving || state == IDLE) begin
      state     <= bus.rcving ? ACTIVE : IDLE;
      phase     <= 3'd0;
      bit_cnt   <= 3'd0;
      ones      <= 3'd0;
      shift_r   <= 1'b0;
      byte_pend <= 1'b0;
      byte_r    <= 1'b0;
      stuff_r   <= 1'b0;
    end else begin
      phase     <= bus.d_edge ? 3'd0 : phase + 3'd1;
      shift_r   <= 1'b0;
      stuff_r   <= 1'b0;
      byte_pend <= 1'b0;
      byte_r    <= byte_pend;
      if (sample) begin
        if (ones == 3'd6) begin
          // Stuffed position: drop the bit, a 1 here is a protocol error.
          ones    <= 3'd0;
          stuff_r <= bus.d_orig;
        end else begin
          ones      <= bus.d_orig ? ones + 3'd1 : 3'd0;
          shift_r   <= 1'b1;
          bit_cnt   <= bit_cnt + 3'd1;
          byte_pend <= (bit_cnt == 3'd7);
        end
      end
    end
  end

  assign bus.shift_enable  = shift_r;
  assign bus.byte_received = byte_r;
  assign bus.stuff_error   = stuff_r;
endmodule

// File: tb/tb_rx_bit_timer.sv
// tb/tb_rx_bit_timer.sv - directed self-checking bench for rx_bit_timer
module tb_rx_bit_timer;
  logic clk;
  logic n_rst;
  int   n_tests;
  int   n_fail;

  int   sh[32];
  int   by[32];
  int   st[32];
  int   n_sh;
  int   n_by;
  int   n_st;
  int   n_consec;

  localparam logic [15:0] ALT   = 16'hAAAA;
  localparam logic [15:0] ZERO  = 16'h0000;
  localparam logic [15:0] ONES6 = 16'h003F;
  localparam logic [15:0] ONES7 = 16'h007F;

  rx_bit_timer_if bus ();

  rx_bit_timer dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Enter ACTIVE and run ncyc cycles; d_orig follows pat per nominal bit period.
  task automatic run(input int ncyc, input int edge_cyc, input logic [15:0] pat);
    logic p_sh, p_by, p_st;
    n_sh = 0; n_by = 0; n_st = 0; n_consec = 0;
    p_sh = 0; p_by = 0; p_st = 0;
    for (int i = 0; i < 32; i++) begin sh[i] = -1; by[i] = -1; st[i] = -1; end
    @(posedge clk); #1;
    bus.rcving = 1'b1;
    bus.d_edge = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      bus.d_edge = (k == edge_cyc);
      bus.d_orig = pat[k / 8];
      @(negedge clk);
      if (bus.shift_enable)  begin if (n_sh < 32) sh[n_sh] = k; n_sh++; end
      if (bus.byte_received) begin if (n_by < 32) by[n_by] = k; n_by++; end
      if (bus.stuff_error)   begin if (n_st < 32) st[n_st] = k; n_st++; end
      if ((p_sh && bus.shift_enable) || (p_by && bus.byte_received) ||
          (p_st && bus.stuff_error))
        n_consec++;
      p_sh = bus.shift_enable;
      p_by = bus.byte_received;
      p_st = bus.stuff_error;
    end
  endtask

  task automatic idle(input int n, output int busy);
    busy = 0;
    @(posedge clk); #1;
    bus.rcving = 1'b0;
    bus.d_edge = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.shift_enable || bus.byte_received || bus.stuff_error) busy++;
    end
  endtask

  initial begin
    int busy;
    int gap_bad;
    n_tests = 0;
    n_fail  = 0;
    n_rst = 1'b0;
    bus.rcving = 1'b1;
    bus.d_edge = 1'b0;
    bus.d_orig = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_shift", int'(bus.shift_enable), 0);
    check("rst_byte", int'(bus.byte_received), 0);
    check("rst_stuff", int'(bus.stuff_error), 0);
    bus.rcving = 1'b0;
    n_rst = 1'b1;
    idle(4, busy);
    check("release_quiet", busy, 0);

    run(64, -1, ALT);
    check("free_nshift", n_sh, 8);
    check("free_first", sh[0], 4);
    check("free_last", sh[7], 60);
    check("free_nbyte", n_by, 1);
    check("free_byte", by[0], 61);
    check("free_nstuff", n_st, 0);
    check("free_consec", n_consec, 0);
    gap_bad = 0;
    for (int i = 1; i < 8; i++) if (sh[i] - sh[i-1] != 8) gap_bad++;
    check("free_period", gap_bad, 0);
    idle(3, busy);
    check("free_idle", busy, 0);

    run(40, 10, ZERO);
    check("resync_nshift", n_sh, 5);
    check("resync_first", sh[0], 4);
    check("resync_next", sh[1], 15);
    check("resync_after", sh[2], 23);
    idle(3, busy);

    run(40, 11, ZERO);
    check("coinc_nshift", n_sh, 4);
    check("coinc_next", sh[1], 16);
    check("coinc_after", sh[2], 24);
    idle(3, busy);

    run(80, -1, ONES6);
    check("stuffok_nshift", n_sh, 9);
    check("stuffok_sixth", sh[5], 44);
    check("stuffok_skip", sh[6], 60);
    check("stuffok_nstuff", n_st, 0);
    check("stuffok_nbyte", n_by, 1);
    check("stuffok_byte", by[0], 69);
    idle(3, busy);

    run(64, -1, ONES7);
    check("stufferr_nshift", n_sh, 7);
    check("stufferr_skip", sh[6], 60);
    check("stufferr_nstuff", n_st, 1);
    check("stufferr_at", st[0], 52);
    check("stufferr_nbyte", n_by, 0);
    check("stufferr_consec", n_consec, 0);
    idle(3, busy);

    run(38, -1, ALT);
    check("abort_pre_nshift", n_sh, 5);
    idle(5, busy);
    check("abort_idle", busy, 0);
    run(64, -1, ALT);
    check("abort_nbyte", n_by, 1);
    check("abort_byte", by[0], 61);
    check("abort_nshift", n_sh, 8);
    idle(3, busy);

    run(37, -1, ALT);
    check("rstmid_pre_nshift", n_sh, 5);
    check("rstmid_shift_seen", sh[4], 36);
    #1;
    n_rst = 1'b0;
    bus.rcving = 1'b0;
    #1;
    check("rstmid_async", int'(bus.shift_enable), 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    idle(4, busy);
    check("rstmid_idle", busy, 0);
    run(64, -1, ALT);
    check("rstmid_nbyte", n_by, 1);
    check("rstmid_byte", by[0], 61);
    check("rstmid_first", sh[0], 4);
    idle(2, busy);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
